fp_unpack_norm: RTL and testbench

//  Operand front end of the FPU: unpacks a packed IEEE-754 operand (double, or single in [31:0]).

---
 rtl/fpu_pkg.sv | 18 +
 rtl/fp_unpack_norm_if.sv | 31 +++
 rtl/lzc53.sv | 15 +
 rtl/fp_unpack_norm.sv | 167 ++++++++++++++++
 tb/tb_fp_unpack_norm.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the operand class encoding used by the operand front end.
package fpu_pkg;

    localparam int          SW     = 53;
    localparam logic [10:0] EMIN   = 11'd1;
    localparam logic [10:0] EMAX_D = 11'd2047;
    localparam logic [10:0] EMAX_S = 11'd255;

    // One-hot class flags; all-zero means a normal number.
    typedef struct packed {
        logic zero;
        logic inf;
        logic qnan;
        logic snan;
        logic denorm;
    } fp_class_t;

endpackage

// File: rtl/fp_unpack_norm_if.sv
// Operand-in / unpacked-result-out handshake bundle of the FPU operand front end.
interface fp_unpack_norm_if
    import fpu_pkg::*;
#(
    parameter int EW  = 11,
    parameter int FW  = 52,
    parameter int LZW = 6
);
    logic           in_valid;
    logic           in_ready;
    logic [63:0]    op;
    logic           db;
    logic           out_valid;
    logic           out_ready;
    logic           s;
    logic [EW-1:0]  er;
    logic [LZW-1:0] lz;
    logic [FW:0]    fn;
    logic           db_o;
    fp_class_t      cls;

    modport slave (
        input  in_valid, op, db, out_ready,
        output in_ready, out_valid, s, er, lz, fn, db_o, cls
    );

    modport master (
        output in_valid, op, db, out_ready,
        input  in_ready, out_valid, s, er, lz, fn, db_o, cls
    );
endinterface

// File: rtl/lzc53.sv
// Combinational leading-zero counter over a 53-bit significand; all-zero input gives 53.
module lzc53 (
    input  logic [52:0] d,
    output logic [5:0]  cnt
);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        cnt = 6'd53;
        for (int i = 0; i < 53; i++) begin
            cnt = d[i] ? 6'(52 - i) : cnt;
        end
    end

endmodule

// File: rtl/fp_unpack_norm.sv
// FPU operand front end: unpack, classify and left-normalize an IEEE-754 operand
// through a two-stage valid/ready pipeline.
module fp_unpack_norm
    import fpu_pkg::*;
#(
    parameter int EW  = 11,
    parameter int FW  = 52,
    parameter int LZW = 6
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    fp_unpack_norm_if.slave   bus
);

    logic           sign_s;
    logic [EW-1:0]  exp_s;
    logic [EW-1:0]  emax_s;
    logic [FW-1:0]  frac_s;
    logic [FW:0]    sig_s;
    logic           e_zero_s;
    logic           e_max_s;
    logic           f_zero_s;
    fp_class_t      cls_s;
    logic [EW-1:0]  er_s;
    logic [5:0]     lzc_s;
    logic [LZW-1:0] lz_s;

    logic           s1_v_r;
    logic           s1_s_r;
    logic [EW-1:0]  s1_er_r;
    logic [LZW-1:0] s1_lz_r;
    logic [FW:0]    s1_sig_r;
    logic           s1_db_r;
    fp_class_t      s1_cls_r;

    logic           s2_v_r;
    logic           s2_s_r;
    logic [EW-1:0]  s2_er_r;
    logic [LZW-1:0] s2_lz_r;
    logic [FW:0]    s2_fn_r;
    logic           s2_db_r;
    fp_class_t      s2_cls_r;

    logic           s2_load_s;
    logic           s1_adv_s;
    logic           in_ready_s;
    logic           in_fire_s;

    // Field extraction; single fraction is left-aligned so its MSB sits where the double's does.
    always_comb begin
        if (bus.db) begin
            sign_s = bus.op[EW+FW];
            exp_s  = bus.op[EW+FW-1:FW];
            frac_s = bus.op[FW-1:0];
            emax_s = EMAX_D;
        end else begin
            sign_s = bus.op[31];
            exp_s  = {{(EW-8){1'b0}}, bus.op[30:23]};
            frac_s = {bus.op[22:0], {(FW-23){1'b0}}};
            emax_s = EMAX_S;
        end
    end

    assign e_zero_s = (exp_s == {EW{1'b0}});
    assign e_max_s  = (exp_s == emax_s);
    assign f_zero_s = (frac_s == {FW{1'b0}});
    assign sig_s    = {~e_zero_s, frac_s};

    // Classification and the exponent/shift pair handed to the rounder.
    always_comb begin
        cls_s        = 5'b00000;
        cls_s.zero   = e_zero_s & f_zero_s;
        cls_s.denorm = e_zero_s & ~f_zero_s;
        cls_s.inf    = e_max_s & f_zero_s;
        cls_s.qnan   = e_max_s & ~f_zero_s & frac_s[FW-1];
        cls_s.snan   = e_max_s & ~f_zero_s & ~frac_s[FW-1];
        er_s         = e_zero_s ? EMIN : exp_s;
        lz_s         = cls_s.denorm ? LZW'(lzc_s) : {LZW{1'b0}};
    end

    lzc53 u_lzc (
        .d   (sig_s),
        .cnt (lzc_s)
    );

    assign s2_load_s  = ~s2_v_r | bus.out_ready;
    assign s1_adv_s   = s1_v_r & s2_load_s;
    assign in_ready_s = ~s1_v_r | s2_load_s;
    assign in_fire_s  = bus.in_valid & in_ready_s & ~flush;

    // Stage 1: capture the unpacked operand on an input transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_s_r   <= 1'b0;
            s1_er_r  <= {EW{1'b0}};
            s1_lz_r  <= {LZW{1'b0}};
            s1_sig_r <= {(FW+1){1'b0}};
            s1_db_r  <= 1'b0;
            s1_cls_r <= 5'b00000;
        end else if (flush) begin
            s1_v_r   <= 1'b0;
            s1_s_r   <= 1'b0;
            s1_er_r  <= {EW{1'b0}};
            s1_lz_r  <= {LZW{1'b0}};
            s1_sig_r <= {(FW+1){1'b0}};
            s1_db_r  <= 1'b0;
            s1_cls_r <= 5'b00000;
        end else begin
            if (in_ready_s) begin
                s1_v_r <= bus.in_valid;
            end
            if (in_fire_s) begin
                s1_s_r   <= sign_s;
                s1_er_r  <= er_s;
                s1_lz_r  <= lz_s;
                s1_sig_r <= sig_s;
                s1_db_r  <= bus.db;
                s1_cls_r <= cls_s;
            end
        end
    end

    // Stage 2: apply the shift; contents hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r   <= 1'b0;
            s2_s_r   <= 1'b0;
            s2_er_r  <= {EW{1'b0}};
            s2_lz_r  <= {LZW{1'b0}};
            s2_fn_r  <= {(FW+1){1'b0}};
            s2_db_r  <= 1'b0;
            s2_cls_r <= 5'b00000;
        end else if (flush) begin
            s2_v_r   <= 1'b0;
            s2_s_r   <= 1'b0;
            s2_er_r  <= {EW{1'b0}};
            s2_lz_r  <= {LZW{1'b0}};
            s2_fn_r  <= {(FW+1){1'b0}};
            s2_db_r  <= 1'b0;
            s2_cls_r <= 5'b00000;
        end else begin
            if (s2_load_s) begin
                s2_v_r <= s1_v_r;
            end
            if (s1_adv_s) begin
                s2_s_r   <= s1_s_r;
                s2_er_r  <= s1_er_r;
                s2_lz_r  <= s1_lz_r;
                s2_fn_r  <= s1_sig_r << s1_lz_r;
                s2_db_r  <= s1_db_r;
                s2_cls_r <= s1_cls_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_v_r;
    assign bus.s         = s2_s_r;
    assign bus.er        = s2_er_r;
    assign bus.lz        = s2_lz_r;
    assign bus.fn        = s2_fn_r;
    assign bus.db_o      = s2_db_r;
    assign bus.cls       = s2_cls_r;

endmodule

// File: tb/tb_fp_unpack_norm.sv
// Self-checking bench for fp_unpack_norm: directed vector table, handshake corner
// sequences, and randomized traffic against a value-level reference model.
module tb_fp_unpack_norm;
    import fpu_pkg::*;

    typedef struct packed {
        logic        s;
        logic [10:0] er;
        logic [5:0]  lz;
        logic [52:0] fn;
        logic [4:0]  cls;
        logic        db;
    } res_t;

    typedef struct {
        logic        db;
        logic [63:0] op;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fp_unpack_norm_if bus ();

    fp_unpack_norm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_out(input string tag, input res_t e);
        chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_s"},     {63'd0, bus.s},    {63'd0, e.s});
        chk({tag, "_er"},    {53'd0, bus.er},   {53'd0, e.er});
        chk({tag, "_lz"},    {58'd0, bus.lz},   {58'd0, e.lz});
        chk({tag, "_fn"},    {11'd0, bus.fn},   {11'd0, e.fn});
        chk({tag, "_cls"},   {59'd0, bus.cls},  {59'd0, e.cls});
        chk({tag, "_db"},    {63'd0, bus.db_o}, {63'd0, e.db});
    endtask

    // Value-level model: normalize the significand by repeated doubling.
    function automatic res_t model(input logic [63:0] op, input logic db);
        res_t        r;
        int          e;
        int          emax;
        int          fw;
        int          k;
        logic [63:0] f;
        logic [63:0] m;
        if (db) begin
            e = int'(op[62:52]); f = {12'd0, op[51:0]}; fw = 52; emax = 2047; r.s = op[63];
        end else begin
            e = int'(op[30:23]); f = {41'd0, op[22:0]}; fw = 23; emax = 255; r.s = op[31];
        end
        r.db  = db;
        r.lz  = 6'd0;
        r.cls = 5'b00000;
        if (e == 0 && f == 64'd0) begin
            r.er = 11'd1; r.fn = 53'd0; r.cls = 5'b10000;
        end else if (e == 0) begin
            m = f;
            k = 0;
            while (m < (64'd1 << fw)) begin
                m = m << 1;
                k++;
            end
            r.er = 11'd1; r.lz = 6'(k); r.fn = 53'(m << (52 - fw)); r.cls = 5'b00001;
        end else begin
            r.er = 11'(e);
            r.fn = 53'(((64'd1 << fw) | f) << (52 - fw));
            if (e == emax)
                r.cls = (f == 64'd0) ? 5'b01000 : (f[fw-1] ? 5'b00100 : 5'b00010);
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_op(input logic db);
        int          cat;
        logic [63:0] r;
        cat = int'($urandom_range(0, 5));
        r   = {$urandom, $urandom};
        if (db) begin
            if (cat == 0) r[62:52] = 11'd0;
            if (cat == 1) r[62:52] = 11'h7FF;
            if (cat == 2) begin r[62:52] = 11'd0; r[51:0] = 52'd1 << $urandom_range(0, 51); end
            if ($urandom_range(0, 3) == 0) r[51:0] = 52'd0;
        end else begin
            if (cat == 0) r[30:23] = 8'd0;
            if (cat == 1) r[30:23] = 8'hFF;
            if (cat == 2) begin r[30:23] = 8'd0; r[22:0] = 23'd1 << $urandom_range(0, 22); end
            if ($urandom_range(0, 3) == 0) r[22:0] = 23'd0;
        end
        return r;
    endfunction

    // One isolated transfer with exact two-cycle latency check.
    task automatic send_check(input string tag, input logic d, input logic [63:0] o, input res_t e);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.db = d; bus.op = o; bus.out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk({tag, "_lat1"}, {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        #1 cmp_out(tag, e);
    endtask

    vec_t        tv[9];
    res_t        q[$];
    res_t        ea;
    res_t        eb;
    res_t        ec;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] op_c;

    initial begin
        tv[0] = '{1'b1, 64'h3FF0000000000000, '{1'b0, 11'h3FF, 6'd0,  53'h10000000000000, 5'b00000, 1'b1}};
        tv[1] = '{1'b1, 64'h0000000000000001, '{1'b0, 11'd1,   6'd52, 53'h10000000000000, 5'b00001, 1'b1}};
        tv[2] = '{1'b1, 64'h8000000000000000, '{1'b1, 11'd1,   6'd0,  53'h0,              5'b10000, 1'b1}};
        tv[3] = '{1'b0, 64'h0000000000400000, '{1'b0, 11'd1,   6'd1,  53'h10000000000000, 5'b00001, 1'b0}};
        tv[4] = '{1'b0, 64'h000000007F800000, '{1'b0, 11'd255, 6'd0,  53'h10000000000000, 5'b01000, 1'b0}};
        tv[5] = '{1'b1, 64'h7FF8000000000000, '{1'b0, 11'd2047, 6'd0, 53'h18000000000000, 5'b00100, 1'b1}};
        tv[6] = '{1'b1, 64'h7FF0000000000001, '{1'b0, 11'd2047, 6'd0, 53'h10000000000001, 5'b00010, 1'b1}};
        tv[7] = '{1'b0, 64'hDEADBEEF3F800000, '{1'b0, 11'd127, 6'd0,  53'h10000000000000, 5'b00000, 1'b0}};
        tv[8] = '{1'b0, 64'h0000000000000001, '{1'b0, 11'd1,   6'd23, 53'h10000000000000, 5'b00001, 1'b0}};

        bus.in_valid = 1'b0; bus.op = 64'd0; bus.db = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        chk("rst_fn",        {11'd0, bus.fn},        64'd0);
        chk("rst_er",        {53'd0, bus.er},        64'd0);
        chk("rst_cls",       {59'd0, bus.cls},       64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            send_check($sformatf("vec%0d", i), tv[i].db, tv[i].op, tv[i].exp);
        end

        // Back-to-back A, B, C with the consumer stalled.
        op_a = 64'h3FF0000000000000; op_b = 64'h4000000000000000; op_c = 64'hC008000000000000;
        ea = model(op_a, 1'b1); eb = model(op_b, 1'b1); ec = model(op_c, 1'b1);
        @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.db = 1'b1; bus.op = op_a;
        @(negedge clk); bus.op = op_b;
        @(negedge clk); bus.op = op_c;
        #1 chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
            cmp_out("hold", ea);
        end
        @(negedge clk); bus.out_ready = 1'b1;
        #1 chk("resume_in_ready", {63'd0, bus.in_ready}, 64'd1);
        cmp_out("seqA", ea);
        @(negedge clk); bus.in_valid = 1'b0;
        #1 cmp_out("seqB", eb);
        @(negedge clk);
        #1 cmp_out("seqC", ec);
        @(negedge clk);
        #1 chk("seq_empty", {63'd0, bus.out_valid}, 64'd0);

        // Asynchronous reset with both stages full.
        @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = op_a;
        @(negedge clk); bus.op = op_b;
        @(negedge clk); bus.in_valid = 1'b0;
        #1 chk("full_before_rst", {63'd0, bus.out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_fn", {11'd0, bus.fn}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("post_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        send_check("after_rst", 1'b1, op_c, ec);

        // Flush with stages full and a competing input.
        @(negedge clk); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.op = op_a;
        @(negedge clk); bus.op = op_b;
        @(negedge clk); flush = 1'b1; bus.op = op_c;
        @(negedge clk); flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        #1 chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_fn", {11'd0, bus.fn}, 64'd0);
        chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("flush_nothing", {63'd0, bus.out_valid}, 64'd0);
        end

        // Randomized traffic against the model with a scoreboard queue.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.db        = 1'($urandom_range(0, 1));
            bus.op        = rand_op(bus.db);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            flush         = ($urandom_range(0, 59) == 0);
            #1;
            chk("rand_in_ready", {63'd0, bus.in_ready},
                {63'd0, !(q.size() == 2 && !bus.out_ready)});
            if (bus.out_valid) begin
                if (q.size() == 0) chk("rand_spurious", {63'd0, bus.out_valid}, 64'd0);
                else cmp_out("rand", q[0]);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (bus.out_valid && bus.out_ready && q.size() > 0) void'(q.pop_front());
                if (bus.in_valid && bus.in_ready) q.push_back(model(bus.op, bus.db));
            end
        end

        @(negedge clk); flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.out_valid) begin
                if (q.size() == 0) chk("drain_spurious", {63'd0, bus.out_valid}, 64'd0);
                else begin
                    cmp_out("drain", q[0]);
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
